// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display reads always win, host writes are fitted into blanking.
// Optional writer-stall statistic enabled by defining FB_ARB_STALL_STAT_EN.
module vga_fb_arbiter #(
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned WR_WINDOW = 64,
    parameter int unsigned MEM_LAT   = 1
) (
    input  logic              clk_in,
    input  logic              resetn,
    input  logic              h_blank,
    input  logic              v_blank,
    input  logic              pix_req,
    input  logic [ADDR_W-1:0] pix_addr,
    output logic              pix_rvalid,
    output logic [DATA_W-1:0] pix_rdata,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       wr_stall_cnt
);

    localparam int unsigned CNT_W = (WR_WINDOW < 1) ? 1 : $clog2(WR_WINDOW + 1);
    localparam logic [CNT_W-1:0] WIN_MAX = CNT_W'(WR_WINDOW);

    typedef enum logic [1:0] {
        S_ACTIVE,
        S_WRITE,
        S_HOLD
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   win_cnt;
    logic               v_blank_q;
    logic [MEM_LAT-1:0] rd_pipe;
    logic               blank;
    logic               wr_fire;

    assign blank    = h_blank | v_blank;
    assign wr_ready = (state == S_WRITE) && !pix_req && (v_blank || (win_cnt < WIN_MAX));
    assign wr_fire  = wr_valid & wr_ready;

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state     <= S_ACTIVE;
            win_cnt   <= '0;
            v_blank_q <= 1'b0;
        end else begin
            v_blank_q <= v_blank;
            unique case (state)
                S_ACTIVE: begin
                    if (blank) begin
                        state   <= S_WRITE;
                        win_cnt <= '0;
                    end
                end
                S_WRITE: begin
                    if (win_cnt != WIN_MAX)
                        win_cnt <= win_cnt + CNT_W'(1);
                    if (!blank)
                        state <= S_ACTIVE;
                    else if (!v_blank && (win_cnt == WIN_MAX))
                        state <= S_HOLD;
                end
                S_HOLD: begin
                    // A new vertical blank reopens writes even mid h-blank
                    if (!blank)
                        state <= S_ACTIVE;
                    else if (v_blank && !v_blank_q) begin
                        state   <= S_WRITE;
                        win_cnt <= '0;
                    end
                end
                default: state <= S_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (pix_req) begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pix_addr;
        end else if (wr_fire) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= mem_en & ~mem_we;
            for (int unsigned i = 1; i < MEM_LAT; i++)
                rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign pix_rvalid = rd_pipe[MEM_LAT-1];
    assign pix_rdata  = mem_rdata;

`ifdef FB_ARB_STALL_STAT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn)
            stall_q <= '0;
        else if (wr_valid && !wr_ready && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end

    assign wr_stall_cnt = stall_q;
`else
    assign wr_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter with a behavioural 1-cycle sync RAM.
module tb_vga_fb_arbiter;

    localparam int unsigned AW  = 17;
    localparam int unsigned DW  = 12;
    localparam int unsigned WIN = 4;
    localparam int unsigned LAT = 1;
`ifdef FB_ARB_STALL_STAT_EN
    localparam int unsigned STALL_EXP = 37;
`else
    localparam int unsigned STALL_EXP = 0;
`endif

    logic          clk_in = 1'b0;
    logic          resetn = 1'b0;
    logic          h_blank = 1'b0, v_blank = 1'b0, pix_req = 1'b0, wr_valid = 1'b0;
    logic [AW-1:0] pix_addr = '0, wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          pix_rvalid, wr_ready, mem_en, mem_we;
    logic [DW-1:0] pix_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [15:0]   wr_stall_cnt;

    int tests = 0;
    int fails = 0;

    vga_fb_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WR_WINDOW(WIN), .MEM_LAT(LAT)
    ) dut (
        .clk_in(clk_in), .resetn(resetn), .h_blank(h_blank), .v_blank(v_blank),
        .pix_req(pix_req), .pix_addr(pix_addr), .pix_rvalid(pix_rvalid), .pix_rdata(pix_rdata),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .wr_stall_cnt(wr_stall_cnt)
    );

    always #5 clk_in = ~clk_in;

    // RAM model: unwritten words read back a fixed address-derived pattern
    logic [DW-1:0] ram [0:4095];
    bit            written [0:4095];

    function automatic logic [DW-1:0] init_word(input int unsigned a);
        return DW'((a * 37 + 5) & 32'hFFF);
    endfunction

    always @(posedge clk_in) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr[11:0]]     <= mem_wdata;
                written[mem_addr[11:0]] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr[11:0]] ? ram[mem_addr[11:0]]
                                                     : init_word(32'(mem_addr[11:0]));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic hb, vb, pr, wv;
        logic rdy, en, we;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int n, hs_cnt, we_cnt, rd_cnt;
        logic hs, exp_rdy;

        //             hb  vb  pr  wv  rdy en  we
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        tbl[2]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0};
        tbl[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1};
        tbl[4]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        tbl[7]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0};
        tbl[8]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
        tbl[9]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1};
        tbl[10] = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        tbl[13] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0};

        // Reset with a pending write request
        h_blank = 1'b1; wr_valid = 1'b1; pix_req = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_rvalid", 32'(pix_rvalid), 0);
        chk("rst_stall", 32'(wr_stall_cnt), 0);
        wr_valid = 1'b0; pix_req = 1'b0; h_blank = 1'b0;
        @(posedge clk_in); #1;
        resetn = 1'b1;
        @(posedge clk_in); #1;

        // Read latency: four back-to-back reads, 1+LAT cycles to data
        for (int k = 0; k < 7; k++) begin
            pix_req  = (k < 4);
            pix_addr = AW'(32'h100 + k);
            @(posedge clk_in); #1;
            chk("rd_mem_en", 32'(mem_en), 32'(k < 4));
            if (k < 4) chk("rd_mem_addr", 32'(mem_addr), 32'h100 + k);
            chk("rd_rvalid", 32'(pix_rvalid), 32'(k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) chk("rd_data", 32'(pix_rdata), 32'(init_word(32'h100 + k - 1)));
        end
        pix_req = 1'b0;

        // Reset while a read result is on the output
        pix_req = 1'b1; pix_addr = AW'(32'h104);
        @(posedge clk_in); #1;
        pix_req = 1'b0;
        @(posedge clk_in); #1;
        chk("mid_rvalid_pre", 32'(pix_rvalid), 1);
        #2 resetn = 1'b0;
        #1 chk("mid_rvalid_rst", 32'(pix_rvalid), 0);
        @(posedge clk_in); #1;
        resetn = 1'b1;
        @(posedge clk_in); #1;

        // Cycle-by-cycle arbitration table
        wr_addr = AW'(32'h600); wr_data = DW'(12'h123); pix_addr = AW'(32'h105);
        for (int i = 0; i < 14; i++) begin
            h_blank = tbl[i].hb; v_blank = tbl[i].vb; pix_req = tbl[i].pr; wr_valid = tbl[i].wv;
            @(negedge clk_in);
            chk($sformatf("tbl%0d_ready", i), 32'(wr_ready), 32'(tbl[i].rdy));
            @(posedge clk_in); #1;
            chk($sformatf("tbl%0d_en", i), 32'(mem_en), 32'(tbl[i].en));
            chk($sformatf("tbl%0d_we", i), 32'(mem_we), 32'(tbl[i].we));
            if (tbl[i].we) chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'h600);
        end
        pix_req = 1'b0; wr_valid = 1'b0;
        @(posedge clk_in); #1;

        // H-blank window of WIN writes, then hold
        h_blank = 1'b1; wr_valid = 1'b1; n = 0; hs_cnt = 0; we_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            wr_addr = AW'(32'h200 + n); wr_data = DW'(32'h50 + n);
            @(negedge clk_in);
            hs = wr_valid & wr_ready;
            if (hs) hs_cnt++;
            if (mem_en & mem_we) we_cnt++;
            @(posedge clk_in); #1;
            if (hs) n++;
        end
        @(negedge clk_in);
        chk("hb_hold_ready", 32'(wr_ready), 0);
        chk("hb_writes", 32'(hs_cnt), WIN);
        chk("hb_mem_we_cnt", 32'(we_cnt), WIN);
        h_blank = 1'b0; wr_valid = 1'b0;
        @(posedge clk_in); #1;

        // V-blank: window limit ignored
        v_blank = 1'b1; wr_valid = 1'b1; n = 0; hs_cnt = 0;
        for (int k = 0; k < 101; k++) begin
            wr_addr = AW'(32'h300 + n); wr_data = DW'(32'hA00 + n);
            @(negedge clk_in);
            hs = wr_valid & wr_ready;
            if (hs) hs_cnt++;
            @(posedge clk_in); #1;
            if (hs) begin
                chk("vb_mem_we", 32'(mem_en & mem_we), 1);
                chk("vb_addr", 32'(mem_addr), 32'h300 + n);
                chk("vb_data", 32'(mem_wdata), 32'hA00 + n);
                n++;
            end
        end
        chk("vb_writes", 32'(hs_cnt), 100);
        v_blank = 1'b0; wr_valid = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;

        // Conflict: reads on even cycles, writer always pending
        v_blank = 1'b1; n = 0; rd_cnt = 0;
        for (int k = 0; k < 21; k++) begin
            pix_req = (k % 2 == 0); pix_addr = AW'(32'h700 + k);
            wr_valid = 1'b1; wr_addr = AW'(32'h500 + n); wr_data = DW'(32'h300 + n);
            exp_rdy = (k > 0) && (k % 2 != 0);
            @(negedge clk_in);
            chk("cf_ready", 32'(wr_ready), 32'(exp_rdy));
            hs = wr_valid & exp_rdy;
            @(posedge clk_in); #1;
            if (pix_rvalid) rd_cnt++;
            chk("cf_en", 32'(mem_en), 32'(pix_req | hs));
            chk("cf_we", 32'(mem_we), 32'(hs));
            if (pix_req) chk("cf_rd_addr", 32'(mem_addr), 32'h700 + k);
            if (hs) begin
                chk("cf_wr_addr", 32'(mem_addr), 32'h500 + n);
                chk("cf_wr_data", 32'(mem_wdata), 32'h300 + n);
                n++;
            end
        end
        pix_req = 1'b0; wr_valid = 1'b0; v_blank = 1'b0;
        @(posedge clk_in); #1;
        if (pix_rvalid) rd_cnt++;
        chk("cf_reads", 32'(rd_cnt), 11);
        chk("cf_writes", 32'(n), 10);
        @(posedge clk_in); #1;

        // Read back words written during v-blank and the conflict run
        for (int k = 0; k < 2; k++) begin
            pix_req = 1'b1; pix_addr = (k == 0) ? AW'(32'h305) : AW'(32'h503);
            @(posedge clk_in); #1;
            pix_req = 1'b0;
            @(posedge clk_in); #1;
            chk("rb_rvalid", 32'(pix_rvalid), 1);
            chk("rb_data", 32'(pix_rdata), (k == 0) ? 32'hA05 : 32'h303);
        end

        // Writer stall statistic during active video
        resetn = 1'b0;
        #2 resetn = 1'b1;
        @(posedge clk_in); #1;
        chk("stall_clear", 32'(wr_stall_cnt), 0);
        wr_valid = 1'b1;
        repeat (37) @(posedge clk_in);
        #1 wr_valid = 1'b0;
        chk("stall_cnt", 32'(wr_stall_cnt), STALL_EXP);
        repeat (3) @(posedge clk_in);
        #1;
        chk("stall_hold", 32'(wr_stall_cnt), STALL_EXP);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
